calc_seq_alu: RTL and testbench

Sequential, parametrised successor to the combinational calculator datapath. Accepts one operation per valid/ready handshake, runs single-cycle ops in one cycle, and runs multiply and divide/modulo iteratively over N cycles. Holds a registered result plus a 5-bit flag vector until the consumer takes it. Sits between the operand/opcode source (switch/UART front end) and the display/result sink.

---
 rtl/calc_seq_alu_pkg.sv | 34 +++
 rtl/calc_seq_alu_if.sv | 25 ++
 rtl/calc_seq_alu_iter_muldiv.sv | 107 ++++++++++
 rtl/calc_seq_alu.sv | 138 +++++++++++++
 tb/tb_calc_seq_alu.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/calc_seq_alu_pkg.sv
// Shared opcode/state encodings and flag bit positions for the sequential calculator.
package calc_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MULDIV,
    DONE
  } state_e;

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_V = 1;
  localparam int unsigned FLG_B = 2;
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_E = 4;
  localparam int unsigned FLG_W = 5;

  function automatic logic is_muldiv(op_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_seq_alu_if.sv
// Request/response handshake bundle between the operand source, the calculator and the result sink.
interface calc_seq_alu_if #(parameter int unsigned N = 4) ();

  logic           in_valid;
  logic           in_ready;
  logic [3:0]     op_select;
  logic [N-1:0]   operand1;
  logic [N-1:0]   operand2;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] resultado;
  logic [4:0]     banderas;
  logic           busy;

  modport master (
    output in_valid, op_select, operand1, operand2, out_ready,
    input  in_ready, out_valid, resultado, banderas, busy
  );

  modport slave (
    input  in_valid, op_select, operand1, operand2, out_ready,
    output in_ready, out_valid, resultado, banderas, busy
  );

endinterface

// File: rtl/calc_seq_alu_iter_muldiv.sv
// Iterative N-cycle shift-add multiplier and restoring divider sharing one iteration counter.
module iter_muldiv #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div0
);

  localparam int unsigned CW = $clog2(N) + 1;

  logic           run_q, run_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   dvsr_q, dvsr_d;
  logic [N:0]     shifted;
  logic [N:0]     trial;

  always_comb begin
    run_d    = run_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    done     = 1'b0;
    shifted  = {rem_q, quo_q[N-1]};
    trial    = shifted - {1'b0, dvsr_q};

    if (start) begin
      run_d    = 1'b1;
      mode_d   = mode;
      cnt_d    = '0;
      mcand_d  = {{N{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
      rem_d    = '0;
      quo_d    = a;
      dvsr_d   = b;
    end else if (run_q) begin
      if (!mode_q) begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end else if (!trial[N]) begin
        // A zero divisor always "fits", yielding all-ones quotient and remainder == dividend.
        rem_d = trial[N-1:0];
        quo_d = {quo_q[N-2:0], 1'b1};
      end else begin
        rem_d = shifted[N-1:0];
        quo_d = {quo_q[N-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(N - 1)) begin
        done  = 1'b1;
        run_d = 1'b0;
      end
    end
  end

  // Results are presented from the next-state values so the consumer can register them on the final edge.
  assign product   = prod_d;
  assign quotient  = quo_d;
  assign remainder = rem_d;
  assign div0      = (dvsr_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      run_q    <= run_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
    end
  end

endmodule

// File: rtl/calc_seq_alu.sv
// Sequential calculator: handshake FSM, single-cycle datapath, flag logic and registered result.
module calc_seq_alu
  import calc_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  calc_seq_alu_if.slave bus
);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  op_e            op_in;
  logic [2*N-1:0] res_q, res_d;
  logic [FLG_W-1:0] flg_q, flg_d;
  logic [2*N-1:0] alu_res, md_res;
  logic [FLG_W-1:0] alu_flg, md_flg;
  logic [N:0]     add_sum;
  logic           md_start, md_mode, md_done, md_div0;
  logic [2*N-1:0] md_product;
  logic [N-1:0]   md_quot, md_rem;

  assign op_in    = op_e'(bus.op_select);
  assign md_start = (state_q == IDLE) && bus.in_valid && is_muldiv(op_in);
  assign md_mode  = (op_in != OP_MUL);

  iter_muldiv #(.N(N)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .mode      (md_mode),
    .a         (bus.operand1),
    .b         (bus.operand2),
    .done      (md_done),
    .product   (md_product),
    .quotient  (md_quot),
    .remainder (md_rem),
    .div0      (md_div0)
  );

  always_comb begin
    alu_res = '0;
    alu_flg = '0;
    add_sum = {1'b0, bus.operand1} + {1'b0, bus.operand2};
    case (op_in)
      OP_ADD: begin
        alu_res[N-1:0] = add_sum[N-1:0];
        alu_flg[FLG_C] = add_sum[N];
      end
      OP_SUB: begin
        alu_res[N-1:0] = bus.operand1 - bus.operand2;
        alu_flg[FLG_B] = (bus.operand2 > bus.operand1);
      end
      OP_AND: alu_res[N-1:0] = bus.operand1 & bus.operand2;
      OP_OR:  alu_res[N-1:0] = bus.operand1 | bus.operand2;
      OP_XOR: alu_res[N-1:0] = bus.operand1 ^ bus.operand2;
      OP_SHL: alu_res = {{N{1'b0}}, bus.operand1} << bus.operand2;
      OP_SHR: alu_res[N-1:0] = bus.operand1 >> bus.operand2;
      OP_MUL, OP_DIV, OP_MOD: alu_res = '0;
      default: alu_flg[FLG_E] = 1'b1;
    endcase
    alu_flg[FLG_Z] = (alu_res == '0);
  end

  always_comb begin
    md_res = '0;
    md_flg = '0;
    case (op_q)
      OP_MUL: begin
        md_res         = md_product;
        md_flg[FLG_V]  = |md_product[2*N-1:N];
      end
      OP_DIV: begin
        md_res[N-1:0]  = md_quot;
        md_flg[FLG_E]  = md_div0;
      end
      default: begin
        md_res[N-1:0]  = md_rem;
        md_flg[FLG_E]  = md_div0;
      end
    endcase
    md_flg[FLG_Z] = (md_res == '0);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    flg_d   = flg_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = op_in;
          if (is_muldiv(op_in)) begin
            state_d = MULDIV;
          end else begin
            res_d   = alu_res;
            flg_d   = alu_flg;
            state_d = DONE;
          end
        end
      end
      MULDIV: begin
        if (md_done) begin
          res_d   = md_res;
          flg_d   = md_flg;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == MULDIV);
  assign bus.resultado = res_q;
  assign bus.banderas  = flg_q;

endmodule

// File: tb/tb_calc_seq_alu.sv
// Scoreboard bench for calc_seq_alu: driver pushes model results, monitor pops on each presented result.
module tb_calc_seq_alu;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_seq_alu_if #(.N(N)) bus ();

  calc_seq_alu #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int op;
    int a;
    int b;
    int res;
    int flg;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   hold = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the arithmetic definitions of each opcode.
  function automatic void model(input int op, input int a, input int b,
                                output int res, output int flg, output int lat);
    int m;
    m   = 1 << N;
    res = 0;
    flg = 0;
    lat = 0;
    case (op)
      0: begin res = (a + b) % m; if (a + b >= m) flg |= 1; end
      1: begin res = (a - b + m) % m; if (b > a) flg |= 4; end
      2: begin res = a * b; if (res >= m) flg |= 2; lat = N; end
      3: begin lat = N; if (b == 0) begin res = m - 1; flg |= 16; end else res = a / b; end
      4: begin lat = N; if (b == 0) begin res = a; flg |= 16; end else res = a % b; end
      5: res = a & b;
      6: res = a | b;
      7: res = a ^ b;
      8: res = (a * (1 << b)) % (m * m);
      9: res = (b >= N) ? 0 : a / (1 << b);
      default: flg |= 16;
    endcase
    if (res == 0) flg |= 8;
  endfunction

  task automatic issue(input int op, input int a, input int b);
    int   res, flg, lat, waitc;
    exp_t e;
    model(op, a, b, res, flg, lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op_select = 4'(op);
    bus.operand1  = 4'(a);
    bus.operand2  = 4'(b);
    waitc = 0;
    while (!bus.in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for op %0d", op);
      bus.in_valid = 1'b0;
      return;
    end
    e = '{op, a, b, res, flg, lat, cyc + 1};
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.op_select = 4'($urandom);
    bus.operand1  = 4'($urandom);
    bus.operand2  = 4'($urandom);
    check("in_ready_after_accept", bus.in_ready, 0);
    check("busy_after_accept", bus.busy, lat != 0);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check("busy_muldiv", bus.busy, 1);
      check("in_ready_muldiv", bus.in_ready, 0);
      check("out_valid_muldiv", bus.out_valid, 0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        have_cur = 1'b0;
      end else if (bus.out_valid) begin
        if (!have_cur) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: out_valid with nothing pending, resultado=0x%0h", bus.resultado);
          end else begin
            cur = sb.pop_front();
            have_cur = 1'b1;
            check($sformatf("latency op%0d", cur.op), cyc - cur.acc, cur.lat);
          end
        end
        if (have_cur) begin
          check($sformatf("resultado op%0d %0d,%0d", cur.op, cur.a, cur.b), bus.resultado, cur.res);
          check($sformatf("banderas op%0d %0d,%0d", cur.op, cur.a, cur.b), bus.banderas, cur.flg);
          if (bus.out_ready) have_cur = 1'b0;
        end
      end
    end
  end

  initial begin
    int waitc;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_select = '0;
    bus.operand1  = '0;
    bus.operand2  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_resultado", bus.resultado, 0);
    check("reset_banderas", bus.banderas, 0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    rst = 1'b0;

    issue(0, 9, 8);
    issue(1, 3, 5);
    issue(2, 15, 15);
    issue(3, 13, 4);
    issue(4, 13, 4);
    issue(3, 7, 0);
    issue(4, 7, 0);
    issue(8, 5, 2);
    issue(9, 5, 4);
    issue(12, 0, 0);

    hold = 1'b1;
    issue(7, 10, 6);
    repeat (5) @(negedge clk);
    check("backpressure_out_valid", bus.out_valid, 1);
    hold = 1'b0;

    // Reset two cycles into a multiply: no result may surface afterwards.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op_select = 4'd2;
    bus.operand1  = 4'd15;
    bus.operand2  = 4'd15;
    waitc = 0;
    while (!bus.in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check("midop_accept", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midop_rst_in_ready", bus.in_ready, 1);
    check("midop_rst_out_valid", bus.out_valid, 0);
    check("midop_rst_busy", bus.busy, 0);
    check("midop_rst_resultado", bus.resultado, 0);
    check("midop_rst_banderas", bus.banderas, 0);
    rst = 1'b0;
    repeat (N + 2) begin
      @(negedge clk);
      check("midop_no_stale", bus.out_valid, 0);
    end
    issue(0, 1, 1);

    repeat (150) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    end

    waitc = 0;
    while ((sb.size() != 0 || have_cur) && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("drain_pending", sb.size() + int'(have_cur), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
